// File: rtl/mode_counter_pkg.sv
// rtl/mode_counter_pkg.sv - shared mode and bounce-state constants for mode_counter
//
// Purpose: MODE encodings and the bounce FSM state type, shared by the
// counter top and its bench.

package mode_counter_pkg;

  localparam logic [1:0] MODE_UP     = 2'b00;
  localparam logic [1:0] MODE_DOWN   = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

  // The bounce state is the DIR output, so the encoding doubles as 0 = up, 1 = down.
  typedef enum logic {
    ST_UP   = 1'b0,
    ST_DOWN = 1'b1
  } bounce_state_t;

endpackage

// File: rtl/mode_counter_tick_prescaler.sv
// rtl/mode_counter_tick_prescaler.sv - clock-enable prescaler producing one tick per PRESCALE enabled clocks
//
// Purpose: free-running 0..PRESCALE-1 phase counter that pauses while EN is low.
// Ports:
//   CLK   - rising-edge clock
//   RESET - synchronous active-high reset, phase -> 0
//   EN    - advance enable; when low the phase holds its value
//   CLR   - synchronous phase clear (used by parallel load)
//   TICK  - combinational, high when the phase is at its last step and EN is high

module tick_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic CLK,
  input  logic RESET,
  input  logic EN,
  input  logic CLR,
  output logic TICK
);

  localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == LAST);

  always_ff @(posedge CLK) begin
    if (RESET || CLR) begin
      r_cnt <= '0;
    end else if (EN) begin
      r_cnt <= w_last ? '0 : r_cnt + PW'(1);
    end
  end

  assign TICK = EN && w_last;

endmodule

// File: rtl/mode_counter.sv
// rtl/mode_counter.sv - modulo-N up/down/bounce counter with prescaled clock enable
//
// Purpose: WIDTH-bit counter over 0..MODULUS-1 that steps once per prescaler
// tick in the selected mode and emits a one-cycle CARRY on wrap/turnaround.
// Ports:
//   CLK      - rising-edge clock
//   RESET    - synchronous active-high reset (Q=0, CARRY=0, DIR=0, prescaler=0)
//   EN       - count enable; freezes count and prescaler when low
//   MODE     - 00 up, 01 down, 10 bounce, 11 hold
//   LOAD     - synchronous parallel load, wins over a coincident tick
//   LOAD_VAL - load value, clamped to MODULUS-1
//   Q        - registered count
//   CARRY    - registered wrap/turnaround pulse
//   DIR      - registered direction, 0 up / 1 down

module mode_counter
  import mode_counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 10,
  parameter int PRESCALE = 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             EN,
  input  logic [1:0]       MODE,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  output logic [WIDTH-1:0] Q,
  output logic             CARRY,
  output logic             DIR
);

  localparam logic [WIDTH-1:0] MAXV  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] BELOW = WIDTH'(MODULUS - 2);
  // One extra bit so MODULUS = 2^WIDTH is representable for the clamp compare.
  localparam logic [WIDTH:0]   MODW  = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] r_q;
  logic             r_carry;
  bounce_state_t    r_state;

  logic [WIDTH-1:0] w_q_nxt;
  logic             w_carry_nxt;
  bounce_state_t    w_state_nxt;
  logic             w_tick;
  logic             w_pre_en;
  logic             w_over;

  assign w_pre_en = EN && (MODE != MODE_HOLD);
  assign w_over   = ({1'b0, LOAD_VAL} >= MODW);

  tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .CLK  (CLK),
    .RESET(RESET),
    .EN   (w_pre_en),
    .CLR  (LOAD),
    .TICK (w_tick)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_q     <= '0;
      r_carry <= 1'b0;
      r_state <= ST_UP;
    end else begin
      r_q     <= w_q_nxt;
      r_carry <= w_carry_nxt;
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_q_nxt     = r_q;
    w_carry_nxt = 1'b0;
    w_state_nxt = r_state;
    if (LOAD) begin
      w_q_nxt = w_over ? MAXV : LOAD_VAL;
    end else if (w_tick) begin
      case (MODE)
        MODE_UP: begin
          w_state_nxt = ST_UP;
          if (r_q == MAXV) begin
            w_q_nxt     = '0;
            w_carry_nxt = 1'b1;
          end else begin
            w_q_nxt = r_q + WIDTH'(1);
          end
        end
        MODE_DOWN: begin
          w_state_nxt = ST_DOWN;
          if (r_q == '0) begin
            w_q_nxt     = MAXV;
            w_carry_nxt = 1'b1;
          end else begin
            w_q_nxt = r_q - WIDTH'(1);
          end
        end
        MODE_BOUNCE: begin
          // Turnaround skips the endpoint so it never appears on two ticks in a row.
          if (r_state == ST_UP) begin
            if (r_q == MAXV) begin
              w_q_nxt     = BELOW;
              w_state_nxt = ST_DOWN;
              w_carry_nxt = 1'b1;
            end else begin
              w_q_nxt = r_q + WIDTH'(1);
            end
          end else begin
            if (r_q == '0) begin
              w_q_nxt     = WIDTH'(1);
              w_state_nxt = ST_UP;
              w_carry_nxt = 1'b1;
            end else begin
              w_q_nxt = r_q - WIDTH'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign Q     = r_q;
  assign CARRY = r_carry;
  assign DIR   = r_state;

endmodule

// File: tb/tb_mode_counter.sv
// tb/tb_mode_counter.sv - self-checking bench for mode_counter across several parameter sets

module tb_mode_counter;

  localparam int NI = 6;
  localparam int MODS[NI] = '{10, 10, 4, 10, 16, 2};
  localparam int PRES[NI] = '{1, 3, 1, 4, 2, 1};

  logic       clk = 1'b0;
  logic       rst, en, load;
  logic [1:0] mode;
  logic [3:0] lval;
  logic [3:0] q_o[NI];
  logic       c_o[NI];
  logic       d_o[NI];

  always #5 clk = ~clk;

  mode_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) u_a (.CLK(clk), .RESET(rst), .EN(en), .MODE(mode),
    .LOAD(load), .LOAD_VAL(lval), .Q(q_o[0]), .CARRY(c_o[0]), .DIR(d_o[0]));
  mode_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(3)) u_b (.CLK(clk), .RESET(rst), .EN(en), .MODE(mode),
    .LOAD(load), .LOAD_VAL(lval), .Q(q_o[1]), .CARRY(c_o[1]), .DIR(d_o[1]));
  mode_counter #(.WIDTH(4), .MODULUS(4), .PRESCALE(1)) u_c (.CLK(clk), .RESET(rst), .EN(en), .MODE(mode),
    .LOAD(load), .LOAD_VAL(lval), .Q(q_o[2]), .CARRY(c_o[2]), .DIR(d_o[2]));
  mode_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(4)) u_d (.CLK(clk), .RESET(rst), .EN(en), .MODE(mode),
    .LOAD(load), .LOAD_VAL(lval), .Q(q_o[3]), .CARRY(c_o[3]), .DIR(d_o[3]));
  mode_counter #(.WIDTH(4), .MODULUS(16), .PRESCALE(2)) u_e (.CLK(clk), .RESET(rst), .EN(en), .MODE(mode),
    .LOAD(load), .LOAD_VAL(lval), .Q(q_o[4]), .CARRY(c_o[4]), .DIR(d_o[4]));
  mode_counter #(.WIDTH(4), .MODULUS(2), .PRESCALE(1)) u_f (.CLK(clk), .RESET(rst), .EN(en), .MODE(mode),
    .LOAD(load), .LOAD_VAL(lval), .Q(q_o[5]), .CARRY(c_o[5]), .DIR(d_o[5]));

  typedef struct {
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic       load;
    logic [3:0] lval;
    int         eq;
    int         ec;
    int         ed;
  } vec_t;

  typedef struct {
    int inst;
    int q;
    int c;
    int d;
  } sb_t;

  vec_t vt[19];
  sb_t  sb_q[$];
  int   m_q[NI], m_pre[NI], m_c[NI], m_d[NI];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   bq[8] = '{1, 2, 3, 2, 1, 0, 1, 2};
  int   bc[8] = '{0, 0, 0, 1, 0, 0, 1, 0};
  int   bd[8] = '{0, 0, 0, 1, 1, 1, 0, 0};

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_edge(input logic r, input logic e, input logic [1:0] m, input logic ld, input logic [3:0] lv);
    for (int i = 0; i < NI; i++) begin
      bit tick;
      tick = e && (m != 2'b11) && (m_pre[i] == PRES[i] - 1);
      m_c[i] = 0;
      if (r) begin
        m_q[i] = 0; m_d[i] = 0; m_pre[i] = 0;
      end else if (ld) begin
        m_q[i] = (int'(lv) >= MODS[i]) ? MODS[i] - 1 : int'(lv);
        m_pre[i] = 0;
      end else begin
        if (e && m != 2'b11) m_pre[i] = tick ? 0 : m_pre[i] + 1;
        if (tick) begin
          if (m == 2'b10) begin
            if (m_d[i] == 0) begin
              if (m_q[i] == MODS[i] - 1) begin m_q[i] = MODS[i] - 2; m_d[i] = 1; m_c[i] = 1; end
              else m_q[i] = m_q[i] + 1;
            end else begin
              if (m_q[i] == 0) begin m_q[i] = 1; m_d[i] = 0; m_c[i] = 1; end
              else m_q[i] = m_q[i] - 1;
            end
          end else if (m == 2'b00) begin
            m_d[i] = 0;
            m_q[i] = (m_q[i] + 1) % MODS[i];
            if (m_q[i] == 0) m_c[i] = 1;
          end else if (m == 2'b01) begin
            m_d[i] = 1;
            m_c[i] = (m_q[i] == 0) ? 1 : 0;
            m_q[i] = (m_q[i] + MODS[i] - 1) % MODS[i];
          end
        end
      end
    end
  endtask

  task automatic cycle(input logic r, input logic e, input logic [1:0] m, input logic ld, input logic [3:0] lv);
    sb_t t;
    @(negedge clk);
    rst = r; en = e; mode = m; load = ld; lval = lv;
    model_edge(r, e, m, ld, lv);
    for (int i = 0; i < NI; i++) sb_q.push_back('{i, m_q[i], m_c[i], m_d[i]});
    @(posedge clk);
    #1;
    while (sb_q.size() > 0) begin
      t = sb_q.pop_front();
      check($sformatf("sb q inst%0d", t.inst), int'(q_o[t.inst]), t.q);
      check($sformatf("sb carry inst%0d", t.inst), int'(c_o[t.inst]), t.c);
      check($sformatf("sb dir inst%0d", t.inst), int'(d_o[t.inst]), t.d);
    end
    cyc++;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'b00; load = 1'b0; lval = 4'd0;

    // Instance A (MODULUS 10, PRESCALE 1): reset, full up run, clamped load over a tick, down, bounce, freezes.
    vt[0] = '{1, 0, 0, 0, 0, 0, 0, 0};
    for (int k = 1; k <= 9; k++) vt[k] = '{0, 1, 0, 0, 0, k, 0, 0};
    vt[10] = '{0, 1, 0, 0, 0, 0, 1, 0};
    vt[11] = '{0, 1, 0, 0, 0, 1, 0, 0};
    vt[12] = '{0, 1, 0, 1, 12, 9, 0, 0};
    vt[13] = '{0, 1, 0, 0, 0, 0, 1, 0};
    vt[14] = '{0, 1, 1, 0, 0, 9, 1, 1};
    vt[15] = '{0, 1, 1, 0, 0, 8, 0, 1};
    vt[16] = '{0, 1, 2, 0, 0, 7, 0, 1};
    vt[17] = '{0, 0, 2, 0, 0, 7, 0, 1};
    vt[18] = '{0, 1, 3, 0, 0, 7, 0, 1};
    for (int k = 0; k < 19; k++) begin
      cycle(vt[k].rst, vt[k].en, vt[k].mode, vt[k].load, vt[k].lval);
      check($sformatf("vec%0d q", k), int'(q_o[0]), vt[k].eq);
      check($sformatf("vec%0d carry", k), int'(c_o[0]), vt[k].ec);
      check($sformatf("vec%0d dir", k), int'(d_o[0]), vt[k].ed);
    end

    // Bounce on MODULUS 4.
    cycle(1, 0, 2'b00, 0, 0);
    for (int k = 0; k < 8; k++) begin
      cycle(0, 1, 2'b10, 0, 0);
      check($sformatf("bounce%0d q", k), int'(q_o[2]), bq[k]);
      check($sformatf("bounce%0d carry", k), int'(c_o[2]), bc[k]);
      check($sformatf("bounce%0d dir", k), int'(d_o[2]), bd[k]);
    end

    // Down with PRESCALE 3.
    cycle(1, 0, 2'b00, 0, 0);
    cycle(0, 1, 2'b01, 0, 0); check("down e1 q", int'(q_o[1]), 0);
    cycle(0, 1, 2'b01, 0, 0); check("down e2 q", int'(q_o[1]), 0);
    cycle(0, 1, 2'b01, 0, 0); check("down e3 q", int'(q_o[1]), 9);
    check("down e3 carry", int'(c_o[1]), 1);
    check("down e3 dir", int'(d_o[1]), 1);
    cycle(0, 1, 2'b01, 0, 0); check("down e4 carry", int'(c_o[1]), 0);
    cycle(0, 1, 2'b01, 0, 0); check("down e5 q", int'(q_o[1]), 9);
    cycle(0, 1, 2'b01, 0, 0); check("down e6 q", int'(q_o[1]), 8);

    // EN / hold freeze with PRESCALE 4, resuming the remaining period.
    cycle(1, 0, 2'b00, 0, 0);
    for (int k = 0; k < 6; k++) cycle(0, 1, 2'b00, 0, 0);
    check("freeze start q", int'(q_o[3]), 1);
    for (int k = 0; k < 5; k++) begin
      cycle(0, 0, 2'b00, 0, 0);
      check("freeze en q", int'(q_o[3]), 1);
    end
    for (int k = 0; k < 5; k++) begin
      cycle(0, 1, 2'b11, 0, 0);
      check("freeze hold q", int'(q_o[3]), 1);
      check("freeze hold carry", int'(c_o[3]), 0);
    end
    cycle(0, 1, 2'b00, 0, 0); check("resume e1 q", int'(q_o[3]), 1);
    cycle(0, 1, 2'b00, 0, 0); check("resume e2 q", int'(q_o[3]), 2);

    // Mid-run bounce-to-up switch at Q=5 going down, then reset.
    cycle(1, 0, 2'b00, 0, 0);
    cycle(0, 1, 2'b01, 0, 0);
    cycle(0, 1, 2'b01, 1, 6); check("switch load q", int'(q_o[0]), 6);
    check("switch load dir", int'(d_o[0]), 1);
    cycle(0, 1, 2'b10, 0, 0); check("switch bounce q", int'(q_o[0]), 5);
    cycle(0, 1, 2'b00, 0, 0); check("switch up q", int'(q_o[0]), 6);
    check("switch up dir", int'(d_o[0]), 0);
    cycle(1, 1, 2'b00, 0, 0); check("switch reset q", int'(q_o[0]), 0);
    check("switch reset dir", int'(d_o[0]), 0);
    check("switch reset carry", int'(c_o[0]), 0);

    // Random traffic against the scoreboard model.
    for (int k = 0; k < 400; k++) begin
      cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 9) == 0), 4'($urandom_range(0, 15)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mode_counter.md
# mode_counter

Parametrised modulo-N counter with selectable counting mode and a built-in clock-enable prescaler. It generalises the fixed 4-bit count/select exercise block. It sits between the board clock and display/output logic, driving a WIDTH-bit count value plus a wrap pulse that can chain further counter stages.

## Interface

**Parameters**
- WIDTH, 4: count register width.
- MODULUS, 10: count range is 0..MODULUS-1. Legal range is 2 ≤ MODULUS ≤ 2^WIDTH.
- PRESCALE, 1: count advances once every PRESCALE enabled clocks. Legal range is PRESCALE ≥ 1.

**Ports**
- CLK, input, 1: single clock. All logic acts on the rising edge.
- RESET, input, 1: synchronous, active-high reset.
- EN, input, 1: count enable. When low, both the count and the prescaler freeze.
- MODE, input, 2: 00 up, 01 down, 10 bounce (up/down ping-pong), 11 hold.
- LOAD, input, 1: synchronous parallel load.
- LOAD_VAL, input, WIDTH: value to load.
- Q, output, WIDTH: current count (registered).
- CARRY, output, 1: one-cycle registered wrap/turnaround pulse.
- DIR, output, 1: current direction, 0 = up, 1 = down (registered).

## Operation

**Reset (RESET=1 at an edge)**
- Q=0, CARRY=0, DIR=0, prescaler=0, bounce FSM returns to UP.
- RESET overrides LOAD, EN and MODE.

**Prescaler**
- Counts 0..PRESCALE-1 while EN=1 and MODE≠11.
- tick=1 when the prescaler is at PRESCALE-1 and EN=1 and MODE≠11. The prescaler wraps to 0 on that edge.
- PRESCALE=1 gives tick on every enabled clock.

**Priority per edge:** RESET > LOAD > tick.

**LOAD**
- Q ← LOAD_VAL. If LOAD_VAL ≥ MODULUS, Q ← MODULUS-1 (clamped).
- Prescaler clears to 0, CARRY=0, DIR unchanged.
- LOAD is independent of EN and MODE.

**Counting on tick**
- Up: Q ← Q+1. At MODULUS-1, wraps to 0 with CARRY=1. DIR ← 0.
- Down: Q ← Q-1. At 0, wraps to MODULUS-1 with CARRY=1. DIR ← 1.
- Bounce: a two-state FSM, UP and DOWN, mirrored on DIR.
  - UP: Q+1. At Q=MODULUS-1, Q ← MODULUS-2, state → DOWN, CARRY=1.
  - DOWN: Q-1. At Q=0, Q ← 1, state → UP, CARRY=1.
  - Entering bounce mode keeps the current DIR as the FSM state.
- Hold: Q, DIR and the prescaler are frozen. CARRY=0.

**CARRY**
- High for exactly the one cycle following the wrap edge.
- 0 on every edge that is not a wrap.

**Width rules**
- All comparisons are against MODULUS-1 computed at WIDTH bits.
- There is no intermediate overflow. Q never leaves 0..MODULUS-1, except when MODULUS=2^WIDTH, where natural wrap coincides.

## Timing

- Latency: Q and CARRY update on the edge where tick or LOAD is sampled. Outputs are valid in the following cycle.
- Consecutive Q changes are spaced by PRESCALE enabled clocks.
- A MODE change takes effect at the next tick. No cycle is lost in the prescaler.
- EN deassert mid-period: the prescaler holds its value and resumes where it left off, so no partial period is lost or restarted.
- LOAD coinciding with tick: the load wins, and the tick is discarded.
- RESET mid-count: the next edge yields the reset values regardless of prescaler phase.
- In bounce mode the sequence never repeats an endpoint value on consecutive ticks.

## Structure

- Shared package `mode_counter_pkg`:
  - mode constants MODE_UP=2'b00, MODE_DOWN=2'b01, MODE_BOUNCE=2'b10, MODE_HOLD=2'b11.
  - bounce FSM state constants ST_UP=1'b0, ST_DOWN=1'b1.
- Natural sub-module: `tick_prescaler` (parameter PRESCALE; ports CLK, RESET, EN, CLR, TICK).
- Count, wrap and FSM logic stay in the top module.

## Test plan

- Reset/up: MODULUS=10, PRESCALE=1, MODE=00, EN=1, pulse RESET. Q runs 0,1,…,9,0. CARRY is high only in the cycle Q=0 after 9. DIR=0.
- Down with prescale: PRESCALE=3, MODE=01. Q steps 0→9→8 every 3 clocks. CARRY pulses once on the 0→9 wrap. DIR=1.
- Bounce: MODULUS=4, MODE=10. Q follows 0,1,2,3,2,1,0,1. CARRY pulses at 3→2 and 0→1. DIR toggles at the same edges.
- Load priority/clamp: LOAD=1 with LOAD_VAL=12 while tick is active. Next Q=9, CARRY=0, prescaler restarts at 0.
- EN/hold freeze: with PRESCALE=4, drop EN for 5 clocks mid-period, then switch MODE=11 for 5 clocks. Q is unchanged throughout. Counting resumes with the remaining period.
- Mid-run mode switch and reset: in bounce mode at Q=5 going down, switch to MODE=00. The next tick gives Q=6, DIR=0. Assert RESET. The next edge gives Q=0, CARRY=0, DIR=0.
